dma_csr_regs: RTL and testbench
===============================

# dma_csr_regs

Parametrised multi-channel control/status register block for the DMA engine. It decodes the single-cycle register bus (addr, wr_en, rd_en, wdata, rdata) and holds per-channel source, destination, length and control registers. It issues one-cycle start pulses to the channel engines and collects their done pulses into W1C status bits and a level interrupt. It sits between the register-bus master (CPU bridge or testbench driver) and the DMA datapath.

## Interface
Parameters:
- NUM_CH, 4: number of DMA channels (1..8).
- ADDR_W, 32: bus address width and SRC/DST register width.
- DATA_W, 32: bus data width (≥ ADDR_W, ≥ LEN_W+0).
- LEN_W, 16: transfer-length field width.

Ports:
- clk  in  1  bus and register clock.
- rst_n  in  1  reset, asynchronous, active-low.
- addr  in  ADDR_W  byte address; bits [1:0] ignored.
- wr_en  in  1  write strobe, sampled at posedge clk.
- rd_en  in  1  read strobe, sampled at posedge clk.
- wdata  in  DATA_W  write data.
- rdata  out  DATA_W  read data, valid with rvalid.
- rvalid  out  1  one-cycle pulse, read data valid.
- ch_src  out  NUM_CH*ADDR_W  per-channel source address.
- ch_dst  out  NUM_CH*ADDR_W  per-channel destination address.
- ch_len  out  NUM_CH*LEN_W  per-channel length.
- ch_start  out  NUM_CH  one-cycle start pulse per channel.
- ch_done  in  NUM_CH  one-cycle completion pulse from engine.
- irq  out  1  level interrupt.
- bus_err  out  1  unmapped-access pulse (only with DMA_CSR_ERR_EN).

## Operation
- Channel c window base = c*0x20. Offsets: 0x00 CTRL (bit0 EN, bit1 IE, bit2 START write-only, reads 0); 0x04 SRC; 0x08 DST; 0x0C LEN (bits above LEN_W read 0); 0x10 STATUS (bit0 BUSY RO, bit1 DONE W1C).
- 0x100 IRQ_STAT, RO: bit c = DONE[c] & IE[c]; other bits 0.
- Any other address, or channel index ≥ NUM_CH: writes ignored, reads return 0.
- Start: write to CTRL with wdata bit2=1, resulting EN=1 and BUSY=0 → ch_start[c] high for exactly one cycle, BUSY set. START while BUSY=1 or EN=0 → ignored, no pulse.
- ch_done[c] pulse → BUSY cleared, DONE set. ch_done while BUSY=0 still sets DONE.
- DONE cleared by writing 1 to STATUS bit1. Same-cycle W1C and ch_done → DONE stays 1.
- irq = |IRQ_STAT, registered.
- Simultaneous wr_en and rd_en on the same cycle: write performed; read returns pre-write value.
- SRC/DST/LEN writable while BUSY; engine samples them on ch_start only.

## Timing
- Reset: rdata=0, rvalid=0, ch_start=0, irq=0, bus_err=0, all registers 0.
- Write: registers update at the posedge where wr_en=1; outputs ch_src/ch_dst/ch_len reflect it from the next cycle.
- Read: rd_en at edge N → rdata/rvalid at edge N+1; rdata holds until next read; rvalid one cycle wide. Back-to-back reads give one result per cycle.
- ch_start asserted the cycle after the CTRL write edge; BUSY reads 1 from the same cycle.
- ch_done at edge N → STATUS reflects at N+1, irq at N+2.
- Reset mid-transfer: BUSY/DONE cleared, pending start pulse dropped.

## Configuration
- DMA_CSR_ERR_EN defined: bus_err pulses one cycle (aligned with rvalid for reads, cycle after the edge for writes) on unmapped access; reads of unmapped addresses return 32'hDEAD_BEEF truncated to DATA_W.
- Undefined: bus_err port absent, unmapped reads return 0.

## Structure
- Package dma_csr_pkg: register offsets, channel stride, IRQ_STAT address, CTRL/STATUS bit positions, unmapped read pattern.
- Sub-module dma_csr_chan: one channel's CTRL/SRC/DST/LEN/STATUS, start/done logic; generated NUM_CH times. Top holds decode, read mux, rdata register, irq.

## Test plan
- Reset, then read 0x00–0x10 of every channel and 0x100 → all 0, irq=0, rvalid one cycle after each rd_en.
- Write ch1 SRC=0x1000_0000, DST=0x2000_0000, LEN=0x1_0040 → ch_src[1]/ch_dst[1] match, LEN reads 0x0040.
- Write ch2 CTRL=0x7 → ch_start[2] one cycle, STATUS=0x1; second CTRL=0x7 while busy → no pulse.
- ch_done[2] pulse → STATUS=0x2, IRQ_STAT=0x4, irq=1 two cycles later; write STATUS=0x2 → irq=0.
- Same-cycle STATUS W1C and ch_done[0] with IE=1 → DONE remains 1, irq stays 1.
- Write/read 0x200 → ignored, rdata=0 (bus_err=1, rdata=0xDEADBEEF with DMA_CSR_ERR_EN).

Source files
------------

// File: rtl/dma_csr_pkg.sv
// Shared register map for the DMA CSR block: offsets, bit positions, decode helper.
package dma_csr_pkg;

  localparam int          CH_STRIDE     = 'h20;
  localparam int          OFF_W         = $clog2(CH_STRIDE);
  localparam int          IRQ_STAT_ADDR = 'h100;

  localparam logic [4:0]  OFF_CTRL = 5'h00;
  localparam logic [4:0]  OFF_SRC  = 5'h04;
  localparam logic [4:0]  OFF_DST  = 5'h08;
  localparam logic [4:0]  OFF_LEN  = 5'h0C;
  localparam logic [4:0]  OFF_STAT = 5'h10;

  localparam int          CTRL_EN_BIT    = 0;
  localparam int          CTRL_IE_BIT    = 1;
  localparam int          CTRL_START_BIT = 2;
  localparam int          STAT_BUSY_BIT  = 0;
  localparam int          STAT_DONE_BIT  = 1;

  localparam logic [31:0] UNMAPPED_RD = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    REG_CTRL, REG_SRC, REG_DST, REG_LEN, REG_STAT, REG_NONE
  } reg_sel_e;

  function automatic reg_sel_e dec_off(input logic [4:0] off);
    case (off)
      OFF_CTRL: return REG_CTRL;
      OFF_SRC:  return REG_SRC;
      OFF_DST:  return REG_DST;
      OFF_LEN:  return REG_LEN;
      OFF_STAT: return REG_STAT;
      default:  return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/dma_csr_chan.sv
// One DMA channel: CTRL/SRC/DST/LEN/STATUS registers plus start-pulse and done capture.
module dma_csr_chan
  import dma_csr_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_wr_ctrl,
  input  logic              i_wr_src,
  input  logic              i_wr_dst,
  input  logic              i_wr_len,
  input  logic              i_wr_stat,
  input  logic              i_done,
  output logic [ADDR_W-1:0] o_src,
  output logic [ADDR_W-1:0] o_dst,
  output logic [LEN_W-1:0]  o_len,
  output logic              o_start,
  output logic              o_en,
  output logic              o_ie,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_irq
);

  logic [ADDR_W-1:0] r_src, r_dst;
  logic [LEN_W-1:0]  r_len;
  logic              r_en, r_ie, r_busy, r_done, r_start;
  logic              w_start;
  logic              w_unused_wdata;

  // START qualifies on the EN value being written, not the old one
  assign w_start = i_wr_ctrl & i_wdata[CTRL_START_BIT] & i_wdata[CTRL_EN_BIT] & ~r_busy;
  assign w_unused_wdata = ^i_wdata;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_src   <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_en    <= 1'b0;
      r_ie    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_start <= 1'b0;
    end else begin
      r_start <= w_start;
      if (i_wr_ctrl) begin
        r_en <= i_wdata[CTRL_EN_BIT];
        r_ie <= i_wdata[CTRL_IE_BIT];
      end
      if (i_wr_src) r_src <= i_wdata[ADDR_W-1:0];
      if (i_wr_dst) r_dst <= i_wdata[ADDR_W-1:0];
      if (i_wr_len) r_len <= i_wdata[LEN_W-1:0];
      if (w_start)     r_busy <= 1'b1;
      else if (i_done) r_busy <= 1'b0;
      // a completion in the same cycle as the W1C wins so no event is lost
      if (i_done)                                      r_done <= 1'b1;
      else if (i_wr_stat && i_wdata[STAT_DONE_BIT])    r_done <= 1'b0;
    end
  end

  assign o_src   = r_src;
  assign o_dst   = r_dst;
  assign o_len   = r_len;
  assign o_start = r_start;
  assign o_en    = r_en;
  assign o_ie    = r_ie;
  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_irq   = r_done & r_ie;

endmodule

// File: rtl/dma_csr_regs.sv
// DMA CSR block: bus decode, per-channel register array, read-data register and irq.
// Optional DMA_CSR_ERR_EN adds o_bus_err and a non-zero pattern for unmapped reads.
module dma_csr_regs
  import dma_csr_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [ADDR_W-1:0]             i_addr,
  input  logic                          i_wr_en,
  input  logic                          i_rd_en,
  input  logic [DATA_W-1:0]             i_wdata,
  output logic [DATA_W-1:0]             o_rdata,
  output logic                          o_rvalid,
  output logic [NUM_CH-1:0][ADDR_W-1:0] o_ch_src,
  output logic [NUM_CH-1:0][ADDR_W-1:0] o_ch_dst,
  output logic [NUM_CH-1:0][LEN_W-1:0]  o_ch_len,
  output logic [NUM_CH-1:0]             o_ch_start,
  input  logic [NUM_CH-1:0]             i_ch_done,
  output logic                          o_irq
`ifdef DMA_CSR_ERR_EN
  , output logic                        o_bus_err
`endif
);

  logic [2:0]        w_ch;
  logic [4:0]        w_off;
  logic              w_ch_ok, w_irq_hit;
  reg_sel_e          w_reg;
  logic [NUM_CH-1:0] w_en, w_ie, w_busy, w_done, w_irq_stat, w_wr;
  logic [DATA_W-1:0] w_rdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rvalid, r_irq;
  logic              w_unused_addr;

  assign w_ch          = i_addr[OFF_W+2:OFF_W];
  assign w_off         = {i_addr[OFF_W-1:2], 2'b00};
  assign w_ch_ok       = (i_addr[ADDR_W-1:OFF_W+3] == '0) && (int'(w_ch) < NUM_CH);
  assign w_irq_hit     = ({i_addr[ADDR_W-1:2], 2'b00} == ADDR_W'(IRQ_STAT_ADDR));
  assign w_reg         = w_ch_ok ? dec_off(w_off) : REG_NONE;
  assign w_unused_addr = ^i_addr[1:0];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign w_wr[c] = i_wr_en & w_ch_ok & (int'(w_ch) == c);
    dma_csr_chan #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) u_chan (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_wdata   (i_wdata),
      .i_wr_ctrl (w_wr[c] & (w_reg == REG_CTRL)),
      .i_wr_src  (w_wr[c] & (w_reg == REG_SRC)),
      .i_wr_dst  (w_wr[c] & (w_reg == REG_DST)),
      .i_wr_len  (w_wr[c] & (w_reg == REG_LEN)),
      .i_wr_stat (w_wr[c] & (w_reg == REG_STAT)),
      .i_done    (i_ch_done[c]),
      .o_src     (o_ch_src[c]),
      .o_dst     (o_ch_dst[c]),
      .o_len     (o_ch_len[c]),
      .o_start   (o_ch_start[c]),
      .o_en      (w_en[c]),
      .o_ie      (w_ie[c]),
      .o_busy    (w_busy[c]),
      .o_done    (w_done[c]),
      .o_irq     (w_irq_stat[c])
    );
  end

`ifdef DMA_CSR_ERR_EN
  logic w_mapped;
  logic r_bus_err;
  assign w_mapped = w_irq_hit | (w_reg != REG_NONE);
`endif

  // read mux samples pre-write state, so a same-cycle write+read returns the old value
  always_comb begin
    w_rdata = '0;
    if (w_irq_hit) begin
      w_rdata[NUM_CH-1:0] = w_irq_stat;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_ch_ok && int'(w_ch) == c) begin
          case (w_reg)
            REG_CTRL: begin
              w_rdata[CTRL_EN_BIT] = w_en[c];
              w_rdata[CTRL_IE_BIT] = w_ie[c];
            end
            REG_SRC:  w_rdata[ADDR_W-1:0] = o_ch_src[c];
            REG_DST:  w_rdata[ADDR_W-1:0] = o_ch_dst[c];
            REG_LEN:  w_rdata[LEN_W-1:0]  = o_ch_len[c];
            REG_STAT: begin
              w_rdata[STAT_BUSY_BIT] = w_busy[c];
              w_rdata[STAT_DONE_BIT] = w_done[c];
            end
            default: ;
          endcase
        end
      end
    end
`ifdef DMA_CSR_ERR_EN
    if (!w_mapped) w_rdata = DATA_W'(UNMAPPED_RD);
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_rvalid <= i_rd_en;
      if (i_rd_en) r_rdata <= w_rdata;
      r_irq <= |w_irq_stat;
    end
  end

`ifdef DMA_CSR_ERR_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_bus_err <= 1'b0;
    else          r_bus_err <= (i_rd_en | i_wr_en) & ~w_mapped;
  end
  assign o_bus_err = r_bus_err;
`endif

  assign o_rdata  = r_rdata;
  assign o_rvalid = r_rvalid;
  assign o_irq    = r_irq;

endmodule

// File: tb/tb_dma_csr_regs.sv
// Directed bench for dma_csr_regs: read results scoreboarded through a queue.
module tb_dma_csr_regs;

  localparam int NUM_CH = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 16;
`ifdef DMA_CSR_ERR_EN
  localparam logic [31:0] UNMAP = 32'hDEAD_BEEF;
`else
  localparam logic [31:0] UNMAP = 32'h0;
`endif

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } exp_t;

  logic                          clk = 1'b0;
  logic                          rst_n = 1'b0;
  logic [ADDR_W-1:0]             addr = '0;
  logic                          wr_en = 1'b0, rd_en = 1'b0;
  logic [DATA_W-1:0]             wdata = '0;
  logic [DATA_W-1:0]             rdata;
  logic                          rvalid;
  logic [NUM_CH-1:0][ADDR_W-1:0] ch_src, ch_dst;
  logic [NUM_CH-1:0][LEN_W-1:0]  ch_len;
  logic [NUM_CH-1:0]             ch_start;
  logic [NUM_CH-1:0]             ch_done = '0;
  logic                          irq;
`ifdef DMA_CSR_ERR_EN
  logic                          bus_err;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  dma_csr_regs #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_addr     (addr),
    .i_wr_en    (wr_en),
    .i_rd_en    (rd_en),
    .i_wdata    (wdata),
    .o_rdata    (rdata),
    .o_rvalid   (rvalid),
    .o_ch_src   (ch_src),
    .o_ch_dst   (ch_dst),
    .o_ch_len   (ch_len),
    .o_ch_start (ch_start),
    .i_ch_done  (ch_done),
    .o_irq      (irq)
`ifdef DMA_CSR_ERR_EN
    , .o_bus_err (bus_err)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance to the next negedge; any read issued at the passed posedge must now be valid
  task automatic tick();
    logic iss;
    exp_t e;
    iss = rd_en;
    @(negedge clk);
    chk("rvalid", 64'(rvalid), 64'(iss));
    if (iss) begin
      if (q.size() == 0) chk("sb_empty", 64'd1, 64'd0);
      else begin
        e = q.pop_front();
        chk($sformatf("rdata@%h", e.a), 64'(rdata), 64'(e.d));
      end
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    addr = a; rd_en = 1'b1;
    e.a = a; e.d = d;
    q.push_back(e);
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_start", 64'(ch_start), 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);
`ifdef DMA_CSR_ERR_EN
    chk("rst_bus_err", 64'(bus_err), 64'd0);
`endif
    rst_n = 1'b1;
    tick();

    // reset values of the whole map, back-to-back reads
    for (int c = 0; c < NUM_CH; c++)
      for (int o = 0; o <= 'h10; o += 4) rd(32'(c * 'h20 + o), 32'h0);
    rd(32'h100, 32'h0);
    tick();
    chk("irq_idle", 64'(irq), 64'd0);

    // ch1 address/length registers
    wr(32'h24, 32'h1000_0000);
    wr(32'h28, 32'h2000_0000);
    wr(32'h2C, 32'h0001_0040);
    tick();
    chk("ch_src1", 64'(ch_src[1]), 64'h1000_0000);
    chk("ch_dst1", 64'(ch_dst[1]), 64'h2000_0000);
    chk("ch_len1", 64'(ch_len[1]), 64'h0040);
    rd(32'h2C, 32'h0000_0040);
    rd(32'h24, 32'h1000_0000);

    // ch2 start, then a second start while busy
    wr(32'h40, 32'h7);
    chk("start2", 64'(ch_start), 64'h4);
    rd(32'h50, 32'h1);
    chk("start2_end", 64'(ch_start), 64'h0);
    rd(32'h40, 32'h3);
    wr(32'h40, 32'h7);
    chk("start_busy", 64'(ch_start), 64'h0);
    tick();
    chk("start_busy2", 64'(ch_start), 64'h0);

    // ch2 done -> status, irq two edges later, W1C clears
    ch_done = 4'b0100;
    tick();
    ch_done = '0;
    chk("irq_n1", 64'(irq), 64'd0);
    tick();
    chk("irq_n2", 64'(irq), 64'd1);
    rd(32'h50, 32'h2);
    rd(32'h100, 32'h4);
    wr(32'h50, 32'h2);
    tick();
    chk("irq_clr", 64'(irq), 64'd0);
    rd(32'h50, 32'h0);

    // ch0: W1C colliding with done keeps DONE
    wr(32'h00, 32'h2);
    ch_done = 4'b0001;
    tick();
    ch_done = '0;
    tick();
    chk("irq_ch0", 64'(irq), 64'd1);
    addr = 32'h10; wdata = 32'h2; wr_en = 1'b1; ch_done = 4'b0001;
    tick();
    wr_en = 1'b0; ch_done = '0;
    tick();
    chk("irq_w1c_race", 64'(irq), 64'd1);
    rd(32'h10, 32'h2);
    rd(32'h100, 32'h1);

    // unmapped accesses
    wr(32'h200, 32'hFFFF_FFFF);
`ifdef DMA_CSR_ERR_EN
    chk("bus_err_wr", 64'(bus_err), 64'd1);
`endif
    rd(32'h200, UNMAP);
`ifdef DMA_CSR_ERR_EN
    chk("bus_err_rd", 64'(bus_err), 64'd1);
`endif
    rd(32'h80, UNMAP);
    rd(32'h14, UNMAP);
    rd(32'h00, 32'h2);
`ifdef DMA_CSR_ERR_EN
    chk("bus_err_ok", 64'(bus_err), 64'd0);
`endif

    // simultaneous write and read of the same register returns the old value
    addr = 32'h04; wdata = 32'hCAFE_0000; wr_en = 1'b1; rd_en = 1'b1;
    begin exp_t e; e.a = 32'h04; e.d = 32'h0; q.push_back(e); end
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    rd(32'h04, 32'hCAFE_0000);
    chk("ch_src0", 64'(ch_src[0]), 64'hCAFE_0000);

    // reset while a start pulse is in flight
    wr(32'h60, 32'h5);
    chk("start3", 64'(ch_start), 64'h8);
    #1 rst_n = 1'b0;
    #1 chk("rst_drop_start", 64'(ch_start), 64'h0);
    chk("rst_irq2", 64'(irq), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    rd(32'h70, 32'h0);
    rd(32'h24, 32'h0);
    rd(32'h10, 32'h0);
    tick();
    chk("sb_drained", 64'(q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
